// File: rtl/iob_fifo_sync_asym_pkg.sv
// iob_fifo_sync_asym_pkg: derived-width helpers shared by the FIFO, its RAM and the bench.
// Optional feature macro used across this slice: IOB_FIFO_SYNC_ASYM_ALMOST_EN.
`ifndef IOB_MAX
`define IOB_MAX(a, b) (((a) > (b)) ? (a) : (b))
`endif
`ifndef IOB_MIN
`define IOB_MIN(a, b) (((a) < (b)) ? (a) : (b))
`endif

package iob_fifo_sync_asym_pkg;

  function automatic int iob_max(input int a, input int b);
    return `IOB_MAX(a, b);
  endfunction

  function automatic int iob_min(input int a, input int b);
    return `IOB_MIN(a, b);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 32'sd0) && ((v & (v - 32'sd1)) == 32'sd0);
  endfunction

  // Address width of one RAM port: full depth on the narrow side, fewer bits on the wide side.
  function automatic int side_addr_w(input int side_w, input int w_w, input int r_w, input int addr_w);
    int mn;
    int mx;
    mn = iob_min(w_w, r_w);
    mx = iob_max(w_w, r_w);
    if (side_w == mn) begin
      return addr_w;
    end else begin
      return addr_w - $clog2(mx / mn);
    end
  endfunction

endpackage

// File: rtl/iob_fifo_sync_asym_if.sv
// iob_fifo_sync_asym_if: write/read handshake bundle of the asymmetric FIFO.
// IOB_FIFO_SYNC_ASYM_ALMOST_EN adds the almost-full/almost-empty flags.
interface iob_fifo_sync_asym_if #(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 10
);
  logic                w_en;
  logic [W_DATA_W-1:0] w_data;
  logic                w_full;
  logic                r_en;
  logic [R_DATA_W-1:0] r_data;
  logic                r_empty;
  logic [ADDR_W:0]     level;
`ifdef IOB_FIFO_SYNC_ASYM_ALMOST_EN
  logic                w_almost_full;
  logic                r_almost_empty;
`endif

  modport master (
    output w_en, w_data, r_en,
    input  w_full, r_data, r_empty, level
`ifdef IOB_FIFO_SYNC_ASYM_ALMOST_EN
    , input w_almost_full, r_almost_empty
`endif
  );

  modport slave (
    input  w_en, w_data, r_en,
    output w_full, r_data, r_empty, level
`ifdef IOB_FIFO_SYNC_ASYM_ALMOST_EN
    , output w_almost_full, r_almost_empty
`endif
  );
endinterface

// File: rtl/iob_ram_2p_asym.sv
// iob_ram_2p_asym: single-clock dual-port RAM, W_DATA_W-wide write port and
// R_DATA_W-wide registered read port over one store of minimum-width words.
// Little-endian: lower slices map to lower minimum-word addresses.
module iob_ram_2p_asym
  import iob_fifo_sync_asym_pkg::*;
#(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 10,
  localparam int W_ADDR_W = side_addr_w(W_DATA_W, W_DATA_W, R_DATA_W, ADDR_W),
  localparam int R_ADDR_W = side_addr_w(R_DATA_W, W_DATA_W, R_DATA_W, ADDR_W)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                w_en,
  input  logic [W_ADDR_W-1:0] w_addr,
  input  logic [W_DATA_W-1:0] w_data,
  input  logic                r_en,
  input  logic [R_ADDR_W-1:0] r_addr,
  output logic [R_DATA_W-1:0] r_data
);
  localparam int MINDATA_W = iob_min(W_DATA_W, R_DATA_W);
  localparam int W_INC     = W_DATA_W / MINDATA_W;
  localparam int R_INC     = R_DATA_W / MINDATA_W;
  localparam int W_SHIFT   = $clog2(W_INC);
  localparam int R_SHIFT   = $clog2(R_INC);

  logic [MINDATA_W-1:0] mem [0:(2**ADDR_W)-1];
  logic [ADDR_W-1:0]    w_base_s;
  logic [ADDR_W-1:0]    r_base_s;

  assign w_base_s = ADDR_W'(w_addr) << W_SHIFT;
  assign r_base_s = ADDR_W'(r_addr) << R_SHIFT;

  // Scatter a wide (or single) write word into consecutive minimum-width cells.
  always_ff @(posedge clk) begin
    if (w_en) begin
      for (int k = 0; k < W_INC; k++) begin
        mem[w_base_s + ADDR_W'(k)] <= w_data[k*MINDATA_W +: MINDATA_W];
      end
    end
  end

  // Gather consecutive cells into the registered read word; holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= {R_DATA_W{1'b0}};
    end else if (r_en) begin
      for (int k = 0; k < R_INC; k++) begin
        r_data[k*MINDATA_W +: MINDATA_W] <= mem[r_base_s + ADDR_W'(k)];
      end
    end
  end
endmodule

// File: rtl/iob_fifo_sync_asym.sv
// iob_fifo_sync_asym: single-clock FIFO with independent write/read widths.
// Owns pointers, occupancy (in minimum-width words) and flags; storage is iob_ram_2p_asym.
// Define IOB_FIFO_SYNC_ASYM_ALMOST_EN for w_almost_full / r_almost_empty.
module iob_fifo_sync_asym
  import iob_fifo_sync_asym_pkg::*;
#(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 10
) (
  input logic                clk,
  input logic                rst_n,
  iob_fifo_sync_asym_if.slave bus
);
  localparam int MAXDATA_W = iob_max(W_DATA_W, R_DATA_W);
  localparam int MINDATA_W = iob_min(W_DATA_W, R_DATA_W);
  localparam int RATIO     = MAXDATA_W / MINDATA_W;
  localparam int W_ADDR_W  = side_addr_w(W_DATA_W, W_DATA_W, R_DATA_W, ADDR_W);
  localparam int R_ADDR_W  = side_addr_w(R_DATA_W, W_DATA_W, R_DATA_W, ADDR_W);
  localparam int W_INC     = W_DATA_W / MINDATA_W;
  localparam int R_INC     = R_DATA_W / MINDATA_W;

  localparam logic [ADDR_W:0]   FULL_TH  = (ADDR_W+1)'((2**ADDR_W) - W_INC);
  localparam logic [ADDR_W:0]   EMPTY_TH = (ADDR_W+1)'(R_INC);
  localparam logic [ADDR_W:0]   W_INC_L  = (ADDR_W+1)'(W_INC);
  localparam logic [ADDR_W:0]   R_INC_L  = (ADDR_W+1)'(R_INC);
  localparam logic [ADDR_W:0]   ZERO_L   = {(ADDR_W+1){1'b0}};
  localparam logic [W_ADDR_W-1:0] W_ONE  = W_ADDR_W'(32'd1);
  localparam logic [R_ADDR_W-1:0] R_ONE  = R_ADDR_W'(32'd1);

  if (!is_pow2(W_DATA_W)) begin : g_bad_w_data_w
    $error("iob_fifo_sync_asym: W_DATA_W must be a power of two");
  end
  if (!is_pow2(R_DATA_W)) begin : g_bad_r_data_w
    $error("iob_fifo_sync_asym: R_DATA_W must be a power of two");
  end
  if (RATIO > (2**ADDR_W)) begin : g_bad_ratio
    $error("iob_fifo_sync_asym: width ratio exceeds FIFO capacity");
  end

  logic [W_ADDR_W-1:0] w_ptr_r;
  logic [R_ADDR_W-1:0] r_ptr_r;
  logic [ADDR_W:0]     level_r;
  logic [ADDR_W:0]     level_next_s;
  logic                w_full_s;
  logic                r_empty_s;
  logic                w_acc_s;
  logic                r_acc_s;

  // Flags from the registered level; each request qualified only by its own flag.
  always_comb begin
    w_full_s     = (level_r > FULL_TH);
    r_empty_s    = (level_r < EMPTY_TH);
    w_acc_s      = bus.w_en & ~w_full_s;
    r_acc_s      = bus.r_en & ~r_empty_s;
    level_next_s = level_r + (w_acc_s ? W_INC_L : ZERO_L) - (r_acc_s ? R_INC_L : ZERO_L);
  end

  // Pointer and occupancy state; pointers wrap naturally at their port depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr_r <= {W_ADDR_W{1'b0}};
      r_ptr_r <= {R_ADDR_W{1'b0}};
      level_r <= ZERO_L;
    end else begin
      if (w_acc_s) begin
        w_ptr_r <= w_ptr_r + W_ONE;
      end
      if (r_acc_s) begin
        r_ptr_r <= r_ptr_r + R_ONE;
      end
      level_r <= level_next_s;
    end
  end

  iob_ram_2p_asym #(
    .W_DATA_W(W_DATA_W),
    .R_DATA_W(R_DATA_W),
    .ADDR_W  (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .w_en  (w_acc_s),
    .w_addr(w_ptr_r),
    .w_data(bus.w_data),
    .r_en  (r_acc_s),
    .r_addr(r_ptr_r),
    .r_data(bus.r_data)
  );

  assign bus.w_full  = w_full_s;
  assign bus.r_empty = r_empty_s;
  assign bus.level   = level_r;

`ifdef IOB_FIFO_SYNC_ASYM_ALMOST_EN
  localparam bit              AF_ALWAYS = (2 * W_INC) > (2**ADDR_W);
  localparam logic [ADDR_W:0] AF_TH     = AF_ALWAYS ? ZERO_L : (ADDR_W+1)'((2**ADDR_W) - (2 * W_INC));
  localparam logic [ADDR_W+1:0] AE_TH   = (ADDR_W+2)'(2 * R_INC);

  assign bus.w_almost_full  = AF_ALWAYS | (level_r > AF_TH);
  assign bus.r_almost_empty = ({1'b0, level_r} < AE_TH);
`endif
endmodule

// File: tb/tb_iob_fifo_sync_asym.sv
// tb_iob_fifo_sync_asym: directed self-checking bench for the asymmetric FIFO.
// Instance a: 32-bit write / 8-bit read; instance b: 8-bit write / 32-bit read; both ADDR_W=4.
module tb_iob_fifo_sync_asym;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  iob_fifo_sync_asym_if #(.W_DATA_W(32), .R_DATA_W(8),  .ADDR_W(4)) bus_a ();
  iob_fifo_sync_asym_if #(.W_DATA_W(8),  .R_DATA_W(32), .ADDR_W(4)) bus_b ();

  iob_fifo_sync_asym #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  iob_fifo_sync_asym #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word4(input logic [7:0] b);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  logic [7:0] q[$];
  logic [7:0] nb;
  logic [7:0] exp_r;
  int         level_m;
  bit         wacc;
  bit         racc;

  initial begin
    bus_a.w_en = 1'b0; bus_a.r_en = 1'b0; bus_a.w_data = 32'h0;
    bus_b.w_en = 1'b0; bus_b.r_en = 1'b0; bus_b.w_data = 8'h0;
    #1 rst_n = 1'b0;
    #2;
    check_val("rst_level",   32'(bus_a.level), 32'd0);
    check_val("rst_empty",   32'(bus_a.r_empty), 32'd1);
    check_val("rst_full",    32'(bus_a.w_full), 32'd0);
    check_val("rst_rdata",   32'(bus_a.r_data), 32'd0);
    check_val("rst_b_empty", 32'(bus_b.r_empty), 32'd1);
`ifdef IOB_FIFO_SYNC_ASYM_ALMOST_EN
    check_val("rst_afull",   32'(bus_a.w_almost_full), 32'd0);
    check_val("rst_aempty",  32'(bus_a.r_almost_empty), 32'd1);
`endif
    #9 rst_n = 1'b1;
    tick();

    // one wide word read back as four little-endian bytes
    bus_a.w_data = 32'h44332211; bus_a.w_en = 1'b1;
    tick();
    bus_a.w_en = 1'b0;
    check_val("t1_level4", 32'(bus_a.level), 32'd4);
    check_val("t1_not_empty", 32'(bus_a.r_empty), 32'd0);
    bus_a.r_en = 1'b1;
    tick(); check_val("t1_byte0", 32'(bus_a.r_data), 32'h11);
    tick(); check_val("t1_byte1", 32'(bus_a.r_data), 32'h22);
    tick(); check_val("t1_byte2", 32'(bus_a.r_data), 32'h33);
    tick(); check_val("t1_byte3", 32'(bus_a.r_data), 32'h44);
    bus_a.r_en = 1'b0;
    check_val("t1_empty", 32'(bus_a.r_empty), 32'd1);
    check_val("t1_level0", 32'(bus_a.level), 32'd0);

    // fill to capacity, an extra write must be dropped
    bus_a.w_en = 1'b1;
    for (int j = 0; j < 4; j++) begin
      bus_a.w_data = word4(8'(4 * j));
      tick();
    end
    bus_a.w_en = 1'b0;
    check_val("t2_level16", 32'(bus_a.level), 32'd16);
    check_val("t2_full", 32'(bus_a.w_full), 32'd1);
    bus_a.w_data = 32'hDEADBEEF; bus_a.w_en = 1'b1;
    tick();
    bus_a.w_en = 1'b0;
    check_val("t2_level_kept", 32'(bus_a.level), 32'd16);
    bus_a.r_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check_val($sformatf("t2_byte%0d", i), 32'(bus_a.r_data), 32'(i));
    end
    bus_a.r_en = 1'b0;
    check_val("t2_empty", 32'(bus_a.r_empty), 32'd1);
    check_val("t2_level0", 32'(bus_a.level), 32'd0);

    // narrow writes assembled into one wide read
    bus_b.w_en = 1'b1;
    bus_b.w_data = 8'h11; tick();
    bus_b.w_data = 8'h22; tick();
    bus_b.w_data = 8'h33; tick();
    bus_b.w_en = 1'b0;
    check_val("t3_level3", 32'(bus_b.level), 32'd3);
    check_val("t3_still_empty", 32'(bus_b.r_empty), 32'd1);
    bus_b.w_data = 8'h44; bus_b.w_en = 1'b1;
    tick();
    bus_b.w_en = 1'b0;
    check_val("t3_not_empty", 32'(bus_b.r_empty), 32'd0);
    check_val("t3_level4", 32'(bus_b.level), 32'd4);
    bus_b.r_en = 1'b1;
    tick();
    bus_b.r_en = 1'b0;
    check_val("t3_word", bus_b.r_data, 32'h44332211);
    check_val("t3_level0", 32'(bus_b.level), 32'd0);

    // sustained simultaneous traffic from level 12, scoreboard across pointer wrap
    nb = 8'h40;
    level_m = 0;
    q.delete();
    bus_a.w_en = 1'b1;
    for (int j = 0; j < 3; j++) begin
      bus_a.w_data = word4(nb);
      tick();
      for (int k = 0; k < 4; k++) q.push_back(nb + 8'(k));
      nb = nb + 8'd4;
      level_m = level_m + 4;
    end
    check_val("t4_level12", 32'(bus_a.level), 32'd12);
    exp_r = 8'h0f;
    bus_a.r_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      bus_a.w_data = word4(nb);
      wacc = (level_m <= 12);
      racc = (level_m >= 1);
      tick();
      if (racc) begin
        exp_r = q.pop_front();
        level_m = level_m - 1;
      end
      if (wacc) begin
        for (int k = 0; k < 4; k++) q.push_back(nb + 8'(k));
        nb = nb + 8'd4;
        level_m = level_m + 4;
      end
      check_val($sformatf("t4_rdata_c%0d", c), 32'(bus_a.r_data), 32'(exp_r));
      check_val($sformatf("t4_level_c%0d", c), 32'(bus_a.level), 32'(level_m));
    end
    bus_a.w_en = 1'b0;
    for (int c = 0; c < 16 && level_m > 0; c++) begin
      tick();
      exp_r = q.pop_front();
      level_m = level_m - 1;
      check_val($sformatf("t4_drain%0d", c), 32'(bus_a.r_data), 32'(exp_r));
    end
    bus_a.r_en = 1'b0;
    check_val("t4_drained", 32'(bus_a.r_empty), 32'd1);

    // reset mid-stream at level 9
    bus_a.w_en = 1'b1;
    for (int j = 0; j < 3; j++) begin
      bus_a.w_data = word4(nb);
      tick();
      nb = nb + 8'd4;
    end
    bus_a.w_en = 1'b0;
    bus_a.r_en = 1'b1;
    tick(); tick(); tick();
    bus_a.r_en = 1'b0;
    check_val("t5_level9", 32'(bus_a.level), 32'd9);
    #1 rst_n = 1'b0;
    #1;
    check_val("t5_rst_level", 32'(bus_a.level), 32'd0);
    check_val("t5_rst_empty", 32'(bus_a.r_empty), 32'd1);
    check_val("t5_rst_full",  32'(bus_a.w_full), 32'd0);
    check_val("t5_rst_rdata", 32'(bus_a.r_data), 32'd0);
    #1 rst_n = 1'b1;
    bus_a.w_data = 32'hA1B2C3D4; bus_a.w_en = 1'b1;
    tick();
    bus_a.w_en = 1'b0;
    bus_a.r_en = 1'b1;
    tick();
    bus_a.r_en = 1'b0;
    check_val("t5_new_data", 32'(bus_a.r_data), 32'hD4);
    check_val("t5_level3", 32'(bus_a.level), 32'd3);

`ifdef IOB_FIFO_SYNC_ASYM_ALMOST_EN
    // almost flags at level 12 and level 1
    bus_a.r_en = 1'b1;
    tick(); tick(); tick();
    bus_a.r_en = 1'b0;
    check_val("t6_level0", 32'(bus_a.level), 32'd0);
    bus_a.w_en = 1'b1;
    tick(); tick(); tick();
    bus_a.w_en = 1'b0;
    check_val("t6_level12", 32'(bus_a.level), 32'd12);
    check_val("t6_afull12", 32'(bus_a.w_almost_full), 32'd1);
    check_val("t6_aempty12", 32'(bus_a.r_almost_empty), 32'd0);
    bus_a.r_en = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    bus_a.r_en = 1'b0;
    check_val("t6_level1", 32'(bus_a.level), 32'd1);
    check_val("t6_aempty1", 32'(bus_a.r_almost_empty), 32'd1);
    check_val("t6_afull1", 32'(bus_a.w_almost_full), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
